// File: rtl/training_epoch_scheduler_if.sv
// Handshake bundle between the epoch scheduler and the datapath units.
//   master : scheduler side (drives start pulses, sample index, optimizer select)
//   slave  : forward / error / weight-update datapath side
// Signals:
//   fwd_start / fwd_done       forward pass start pulse / completion pulse
//   SQUARED_ERROR / err_valid  per-sample squared error and its valid strobe
//   upd_start / upd_done       weight update start pulse / completion pulse
//   sample_idx                 sample being processed
//   adam_signal                high during the update phase when Adam is used
//   manhatten_signal           high during the update phase when Manhattan is used
interface training_epoch_scheduler_if #(
   parameter int ERR_W    = 34,
   parameter int SAMPLE_W = 4
);
   logic                fwd_start;
   logic                fwd_done;
   logic [ERR_W-1:0]    SQUARED_ERROR;
   logic                err_valid;
   logic                upd_start;
   logic                upd_done;
   logic [SAMPLE_W-1:0] sample_idx;
   logic                adam_signal;
   logic                manhatten_signal;

   modport master (
      output fwd_start, upd_start, sample_idx, adam_signal, manhatten_signal,
      input  fwd_done, SQUARED_ERROR, err_valid, upd_done
   );

   modport slave (
      input  fwd_start, upd_start, sample_idx, adam_signal, manhatten_signal,
      output fwd_done, SQUARED_ERROR, err_valid, upd_done
   );
endinterface

// File: rtl/training_epoch_scheduler.sv
// Sequences one training run: per sample it starts the forward pass, collects
// the squared error and starts the weight update; at each epoch end it checks
// the accumulated error against the convergence and optimizer-switch thresholds.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   training_mode     level, high = run, low = idle / abort
//   err_threshold     convergence threshold on the epoch error
//   switch_threshold  Adam -> Manhattan switch threshold on the epoch error
//   dp                handshake bundle to the datapath units (master side)
//   epoch_count       current epoch, 0-based
//   epoch_error       accumulated error of the last completed epoch
//   training_done     level, run finished
//   timeout           level, run finished by epoch limit rather than convergence
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for training_mode; start clears the run registers
// S_FWD       | forward pass; fwd_start on first cycle, wait fwd_done
// S_ERR       | wait err_valid, accumulate squared error
// S_UPD       | weight update; upd_start on first cycle, wait upd_done
// S_EPOCH_END | latch epoch error, decide done / timeout / next epoch
// S_DONE      | training_done held until training_mode drops
module training_epoch_scheduler #(
   parameter int ERR_W      = 34,
   parameter int N_SAMPLES  = 16,
   parameter int SAMPLE_W   = 4,
   parameter int MAX_EPOCHS = 1024,
   parameter int EPOCH_W    = 10,
   parameter int ACC_W      = ERR_W + SAMPLE_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     training_mode,
   input  logic [ACC_W-1:0]         err_threshold,
   input  logic [ACC_W-1:0]         switch_threshold,
   training_epoch_scheduler_if.master dp,
   output logic [EPOCH_W-1:0]       epoch_count,
   output logic [ACC_W-1:0]         epoch_error,
   output logic                     training_done,
   output logic                     timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FWD,
      S_ERR,
      S_UPD,
      S_EPOCH_END,
      S_DONE
   } state_t;

   localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(N_SAMPLES - 1);
   localparam logic [EPOCH_W-1:0]  LAST_EPOCH  = EPOCH_W'(MAX_EPOCHS - 1);

   state_t              state;
   state_t              state_next;
   logic                first_q;   // first cycle spent in the current state
   logic [ACC_W-1:0]    acc;
   logic [SAMPLE_W-1:0] sample_q;
   logic                manh_q;    // optimizer: 0 = Adam, 1 = Manhattan
   logic [ERR_W-1:0]    sq_err;

   logic run_clr;
   logic acc_add;
   logic idx_inc;
   logic epoch_latch;
   logic epoch_adv;
   logic manh_set;
   logic to_set;
   logic to_clr;

   assign sq_err = dp.SQUARED_ERROR;

   always_comb begin
      state_next  = state;
      run_clr     = 1'b0;
      acc_add     = 1'b0;
      idx_inc     = 1'b0;
      epoch_latch = 1'b0;
      epoch_adv   = 1'b0;
      manh_set    = 1'b0;
      to_set      = 1'b0;
      to_clr      = 1'b0;
      case (state)
         S_IDLE: begin
            if (training_mode) begin
               state_next = S_FWD;
               run_clr    = 1'b1;
            end
         end
         S_FWD: begin
            if (!training_mode)
               state_next = S_IDLE;
            else if (!first_q && dp.fwd_done)
               state_next = S_ERR;
         end
         S_ERR: begin
            if (!training_mode)
               state_next = S_IDLE;
            else if (dp.err_valid) begin
               acc_add    = 1'b1;
               state_next = S_UPD;
            end
         end
         S_UPD: begin
            if (!training_mode)
               state_next = S_IDLE;
            else if (!first_q && dp.upd_done) begin
               if (sample_q == LAST_SAMPLE)
                  state_next = S_EPOCH_END;
               else begin
                  idx_inc    = 1'b1;
                  state_next = S_FWD;
               end
            end
         end
         S_EPOCH_END: begin
            // The epoch itself completed, so its error is reported even on abort.
            epoch_latch = 1'b1;
            if (!training_mode)
               state_next = S_IDLE;
            else if (acc < err_threshold)
               state_next = S_DONE;
            else if (epoch_count == LAST_EPOCH) begin
               state_next = S_DONE;
               to_set     = 1'b1;
            end else begin
               epoch_adv  = 1'b1;
               manh_set   = (acc < switch_threshold);
               state_next = S_FWD;
            end
         end
         S_DONE: begin
            if (!training_mode) begin
               state_next = S_IDLE;
               to_clr     = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         first_q     <= 1'b0;
         acc         <= '0;
         sample_q    <= '0;
         epoch_count <= '0;
         epoch_error <= '0;
         manh_q      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state   <= state_next;
         first_q <= (state_next != state);
         if (run_clr) begin
            acc         <= '0;
            sample_q    <= '0;
            epoch_count <= '0;
            manh_q      <= 1'b0;
            timeout     <= 1'b0;
         end
         if (acc_add)
            acc <= acc + ACC_W'(sq_err);
         if (idx_inc)
            sample_q <= sample_q + SAMPLE_W'(1);
         if (epoch_latch)
            epoch_error <= acc;
         if (epoch_adv) begin
            epoch_count <= epoch_count + EPOCH_W'(1);
            acc         <= '0;
            sample_q    <= '0;
         end
         if (manh_set)
            manh_q <= 1'b1;   // sticky for the rest of the run
         if (to_set)
            timeout <= 1'b1;
         if (to_clr)
            timeout <= 1'b0;
      end
   end

   assign training_done       = (state == S_DONE);
   assign dp.fwd_start        = (state == S_FWD) && first_q;
   assign dp.upd_start        = (state == S_UPD) && first_q;
   assign dp.adam_signal      = (state == S_UPD) && !manh_q;
   assign dp.manhatten_signal = (state == S_UPD) && manh_q;
   assign dp.sample_idx       = sample_q;

endmodule
